// File: rtl/el2_pkg.sv
// Shared types for the EL2 DCCM port arbiter.
// The arbiter is either zero-filling the banks or serving requesters.
package el2_pkg;

    typedef enum logic {
        INIT = 1'b0,
        RUN  = 1'b1
    } el2_dccm_arb_state_e;

endpackage

// File: rtl/el2_dccm_init_seq.sv
// Power-on zero-fill sequencer for the DCCM banks.
// Walks every bank row once, then hands the banks over to the arbiter.
module el2_dccm_init_seq
    import el2_pkg::*;
#(
    parameter int IDX_W = 12
) (
    input  logic             clk,
    input  logic             rst_l,
    output logic             init_active,
    output logic [IDX_W-1:0] init_row,
    output logic             init_done
);

    el2_dccm_arb_state_e state;

    always_ff @(posedge clk or negedge rst_l) begin
        if (!rst_l) begin
            state     <= INIT;
            init_row  <= '0;
            init_done <= 1'b0;
        end else begin
            unique case (state)
                INIT: begin
                    init_row <= init_row + IDX_W'(1);
                    if (&init_row) begin
                        state     <= RUN;
                        init_done <= 1'b1;
                    end
                end
                RUN: begin
                    state <= RUN;
                end
            endcase
        end
    end

    assign init_active = (state == INIT);

endmodule

// File: rtl/el2_dccm_port_arb.sv
// Two-port (LSU/DMA) arbiter onto the banked DCCM SRAMs.
// Grants both ports on disjoint banks, round-robins on bank conflicts.
module el2_dccm_port_arb
    import el2_pkg::*;
#(
    parameter int DCCM_BITS       = 16,
    parameter int DCCM_NUM_BANKS  = 4,
    parameter int DCCM_DATA_WIDTH = 32,
    parameter int DCCM_ECC_WIDTH  = 7,
    localparam int BANK_BITS      = $clog2(DCCM_NUM_BANKS),
    localparam int IDX_W          = DCCM_BITS - BANK_BITS - 2
) (
    input  logic                                           clk,
    input  logic                                           rst_l,
    output logic                                           init_done,
    input  logic [1:0]                                     req,
    input  logic [1:0]                                     we,
    input  logic [1:0][DCCM_BITS-1:0]                      addr,
    input  logic [1:0][DCCM_DATA_WIDTH-1:0]                wdata,
    input  logic [1:0][DCCM_ECC_WIDTH-1:0]                 wecc,
    output logic [1:0]                                     gnt,
    output logic [1:0]                                     rvalid,
    output logic [1:0][DCCM_DATA_WIDTH-1:0]                rdata,
    output logic [1:0][DCCM_ECC_WIDTH-1:0]                 recc,
    output logic [DCCM_NUM_BANKS-1:0]                      dccm_clken,
    output logic [DCCM_NUM_BANKS-1:0]                      dccm_wren_bank,
    output logic [DCCM_NUM_BANKS-1:0][IDX_W-1:0]           dccm_addr_bank,
    output logic [DCCM_NUM_BANKS-1:0][DCCM_DATA_WIDTH-1:0] dccm_wr_data_bank,
    output logic [DCCM_NUM_BANKS-1:0][DCCM_ECC_WIDTH-1:0]  dccm_wr_ecc_bank,
    input  logic [DCCM_NUM_BANKS-1:0][DCCM_DATA_WIDTH-1:0] dccm_bank_dout,
    input  logic [DCCM_NUM_BANKS-1:0][DCCM_ECC_WIDTH-1:0]  dccm_bank_ecc
);

    logic                       init_active;
    logic [IDX_W-1:0]           init_row;
    logic [1:0][BANK_BITS-1:0]  bank;
    logic [1:0][IDX_W-1:0]      idx;
    logic [1:0][BANK_BITS-1:0]  bank_q;
    logic                       ptr;
    logic                       conflict;
    logic                       unused_byte_offset;

    el2_dccm_init_seq #(
        .IDX_W (IDX_W)
    ) u_init_seq (
        .clk         (clk),
        .rst_l       (rst_l),
        .init_active (init_active),
        .init_row    (init_row),
        .init_done   (init_done)
    );

    always_comb begin
        for (int p = 0; p < 2; p++) begin
            bank[p] = addr[p][BANK_BITS+1:2];
            idx[p]  = addr[p][DCCM_BITS-1:BANK_BITS+2];
        end
    end

    // Bank accesses are word-wide; the byte offset never reaches the SRAM.
    assign unused_byte_offset = ^{addr[0][1:0], addr[1][1:0]};

    assign conflict = (&req) && (bank[0] == bank[1]);
    assign gnt[0]   = ~init_active & req[0] & (~conflict | ~ptr);
    assign gnt[1]   = ~init_active & req[1] & (~conflict | ptr);

    // Pointer moves to the loser, and only when a conflict was resolved.
    always_ff @(posedge clk or negedge rst_l) begin
        if (!rst_l) begin
            ptr <= 1'b0;
        end else if (~init_active & conflict) begin
            ptr <= ~ptr;
        end
    end

    always_comb begin
        for (int b = 0; b < DCCM_NUM_BANKS; b++) begin
            dccm_clken[b]        = 1'b0;
            dccm_wren_bank[b]    = 1'b0;
            dccm_addr_bank[b]    = '0;
            dccm_wr_data_bank[b] = '0;
            dccm_wr_ecc_bank[b]  = '0;
            if (init_active) begin
                dccm_clken[b]     = 1'b1;
                dccm_wren_bank[b] = 1'b1;
                dccm_addr_bank[b] = init_row;
            end else begin
                for (int p = 0; p < 2; p++) begin
                    if (gnt[p] && (bank[p] == BANK_BITS'(b))) begin
                        dccm_clken[b]        = 1'b1;
                        dccm_wren_bank[b]    = we[p];
                        dccm_addr_bank[b]    = idx[p];
                        dccm_wr_data_bank[b] = wdata[p];
                        dccm_wr_ecc_bank[b]  = wecc[p];
                    end
                end
            end
        end
    end

    always_ff @(posedge clk or negedge rst_l) begin
        if (!rst_l) begin
            rvalid <= '0;
            bank_q <= '0;
        end else begin
            for (int p = 0; p < 2; p++) begin
                rvalid[p] <= gnt[p] & ~we[p];
                if (gnt[p] & ~we[p]) begin
                    bank_q[p] <= bank[p];
                end
            end
        end
    end

    always_comb begin
        for (int p = 0; p < 2; p++) begin
            rdata[p] = dccm_bank_dout[bank_q[p]];
            recc[p]  = dccm_bank_ecc[bank_q[p]];
        end
    end

endmodule

// File: tb/tb_el2_dccm_port_arb.sv
// Scoreboard bench for el2_dccm_port_arb with an SRAM model behind the banks.
module tb_el2_dccm_port_arb;

    localparam int AW    = 16;
    localparam int NB    = 4;
    localparam int DW    = 32;
    localparam int EW    = 7;
    localparam int IDX_W = 12;
    localparam int DEPTH = 1 << IDX_W;

    logic clk = 1'b0;
    logic rst_l = 1'b0;
    logic init_done;
    logic [1:0] req = '0;
    logic [1:0] we = '0;
    logic [1:0][AW-1:0] addr = '0;
    logic [1:0][DW-1:0] wdata = '0;
    logic [1:0][EW-1:0] wecc = '0;
    logic [1:0] gnt, rvalid;
    logic [1:0][DW-1:0] rdata;
    logic [1:0][EW-1:0] recc;
    logic [NB-1:0] dccm_clken, dccm_wren_bank;
    logic [NB-1:0][IDX_W-1:0] dccm_addr_bank;
    logic [NB-1:0][DW-1:0] dccm_wr_data_bank;
    logic [NB-1:0][EW-1:0] dccm_wr_ecc_bank;
    logic [NB-1:0][DW-1:0] dccm_bank_dout;
    logic [NB-1:0][EW-1:0] dccm_bank_ecc;

    always #5 clk = ~clk;

    el2_dccm_port_arb dut (
        .clk               (clk),
        .rst_l             (rst_l),
        .init_done         (init_done),
        .req               (req),
        .we                (we),
        .addr              (addr),
        .wdata             (wdata),
        .wecc              (wecc),
        .gnt               (gnt),
        .rvalid            (rvalid),
        .rdata             (rdata),
        .recc              (recc),
        .dccm_clken        (dccm_clken),
        .dccm_wren_bank    (dccm_wren_bank),
        .dccm_addr_bank    (dccm_addr_bank),
        .dccm_wr_data_bank (dccm_wr_data_bank),
        .dccm_wr_ecc_bank  (dccm_wr_ecc_bank),
        .dccm_bank_dout    (dccm_bank_dout),
        .dccm_bank_ecc     (dccm_bank_ecc)
    );

    // Synchronous SRAM banks: read data appears the cycle after clken.
    logic [DW+EW-1:0] sram [NB][DEPTH];
    always @(posedge clk) begin
        for (int b = 0; b < NB; b++) begin
            if (dccm_clken[b]) begin
                if (dccm_wren_bank[b])
                    sram[b][dccm_addr_bank[b]] <= {dccm_wr_ecc_bank[b], dccm_wr_data_bank[b]};
                else
                    {dccm_bank_ecc[b], dccm_bank_dout[b]} <= sram[b][dccm_addr_bank[b]];
            end
        end
    end

    int checks = 0;
    int errors = 0;

    task automatic chk(string name, logic [63:0] act, logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h, required %0h (t=%0t)", name, act, exp, $time);
        end
    endtask

    // Reference model: flat word memory, arbitration pointer, init counter.
    logic [DW+EW-1:0] ref_mem [int];
    logic [DW+EW-1:0] exp0 [$];
    logic [DW+EW-1:0] exp1 [$];
    int init_cnt = 0;
    bit mptr = 1'b0;
    bit [1:0] pend = '0;
    bit [1:0] gseen = '0;
    int gcount [2];

    function automatic logic [DW+EW-1:0] mem_rd(int key);
        if (ref_mem.exists(key)) return ref_mem[key];
        return '0;
    endfunction

    always @(negedge clk) begin
        logic [1:0] eg;
        int bk [2];
        int ix [2];
        logic [NB-1:0] xclk;
        logic [NB-1:0] xwr;
        logic [DW+EW-1:0] v;
        bit ok;
        if (!rst_l) begin
            chk("rst_rvalid", {62'd0, rvalid}, 64'd0);
            chk("rst_init_done", {63'd0, init_done}, 64'd0);
            init_cnt = 0;
            mptr = 1'b0;
            pend = '0;
            gseen = '0;
            exp0.delete();
            exp1.delete();
            ref_mem.delete();
        end else if (init_cnt < DEPTH) begin
            ok = (dccm_clken == '1) && (dccm_wren_bank == '1) && (gnt == 2'b00)
                 && (init_done == 1'b0) && (rvalid == 2'b00);
            for (int b = 0; b < NB; b++) begin
                if (dccm_addr_bank[b] != IDX_W'(init_cnt)) ok = 1'b0;
                if (dccm_wr_data_bank[b] != '0 || dccm_wr_ecc_bank[b] != '0) ok = 1'b0;
            end
            checks++;
            if (!ok) begin
                errors++;
                $display("FAIL init_row %0d: clken=%h wren=%h addr0=%0d gnt=%b done=%b rvalid=%b, required clken=f wren=f addr=%0d gnt=0 done=0 rvalid=0",
                         init_cnt, dccm_clken, dccm_wren_bank, dccm_addr_bank[0], gnt, init_done, rvalid, init_cnt);
            end
            init_cnt++;
            gseen = '0;
        end else begin
            chk("init_done", {63'd0, init_done}, 64'd1);
            for (int p = 0; p < 2; p++) begin
                chk($sformatf("rvalid%0d", p), {63'd0, rvalid[p]}, {63'd0, pend[p]});
                if (pend[p]) begin
                    if (p == 0) v = exp0.pop_front();
                    else v = exp1.pop_front();
                    if (rvalid[p]) begin
                        chk($sformatf("rdata%0d", p), {32'd0, rdata[p]}, {32'd0, v[DW-1:0]});
                        chk($sformatf("recc%0d", p), {57'd0, recc[p]}, {57'd0, v[DW+EW-1:DW]});
                    end
                end
            end
            for (int p = 0; p < 2; p++) begin
                bk[p] = (int'(addr[p]) / 4) % NB;
                ix[p] = int'(addr[p]) / (4 * NB);
            end
            eg = req;
            if (req == 2'b11 && bk[0] == bk[1]) begin
                eg = mptr ? 2'b10 : 2'b01;
                mptr = ~mptr;
            end
            chk("gnt", {62'd0, gnt}, {62'd0, eg});
            xclk = '0;
            xwr = '0;
            for (int p = 0; p < 2; p++) begin
                if (eg[p]) begin
                    xclk[bk[p]] = 1'b1;
                    xwr[bk[p]] = we[p];
                    chk("bank_addr", {52'd0, dccm_addr_bank[bk[p]]}, 64'(ix[p]));
                end
            end
            chk("clken", {60'd0, dccm_clken}, {60'd0, xclk});
            chk("wren", {60'd0, dccm_wren_bank}, {60'd0, xwr});
            for (int p = 0; p < 2; p++) begin
                pend[p] = eg[p] & ~we[p];
                if (eg[p] && !we[p]) begin
                    if (p == 0) exp0.push_back(mem_rd(int'(addr[p]) / 4));
                    else exp1.push_back(mem_rd(int'(addr[p]) / 4));
                end
            end
            for (int p = 0; p < 2; p++)
                if (eg[p] && we[p]) ref_mem[int'(addr[p]) / 4] = {wecc[p], wdata[p]};
            gseen = gnt;
            for (int p = 0; p < 2; p++)
                if (gnt[p]) gcount[p]++;
        end
    end

    typedef struct {
        bit w;
        logic [AW-1:0] a;
        logic [DW-1:0] d;
        logic [EW-1:0] e;
    } item_t;

    item_t q0 [$];
    item_t q1 [$];
    bit [1:0] busy = '0;

    task automatic push(int p, bit w, int a, logic [DW-1:0] d, logic [EW-1:0] e);
        item_t it;
        it.w = w;
        it.a = AW'(a);
        it.d = d;
        it.e = e;
        if (p == 0) q0.push_back(it);
        else q1.push_back(it);
    endtask

    // Driver: holds each request until granted, then issues the next one.
    initial begin
        item_t it;
        forever begin
            @(posedge clk);
            #2;
            if (!rst_l) begin
                req = '0;
                busy = '0;
            end else begin
                for (int p = 0; p < 2; p++) begin
                    if (busy[p] && gseen[p]) begin
                        busy[p] = 1'b0;
                        req[p] = 1'b0;
                    end
                    if (!busy[p] && ((p == 0) ? q0.size() : q1.size()) > 0) begin
                        it = (p == 0) ? q0.pop_front() : q1.pop_front();
                        we[p] = it.w;
                        addr[p] = it.a;
                        wdata[p] = it.d;
                        wecc[p] = it.e;
                        req[p] = 1'b1;
                        busy[p] = 1'b1;
                    end
                end
            end
        end
    end

    task automatic drain(string name, int limit);
        int n = 0;
        while ((q0.size() != 0 || q1.size() != 0 || busy != 0 || pend != 0) && n < limit) begin
            @(posedge clk);
            n++;
        end
        checks++;
        if (n >= limit) begin
            errors++;
            $display("FAIL drain_%s: still busy after %0d cycles, required idle", name, n);
        end
        repeat (2) @(posedge clk);
    endtask

    initial begin
        #1_000_000;
        $display("FAIL watchdog: simulation did not finish, required completion");
        $fatal(1, "watchdog");
    end

    initial begin
        int g0;
        int n;
        gcount[0] = 0;
        gcount[1] = 0;
        repeat (3) @(posedge clk);
        push(0, 1'b0, 'h0008, '0, '0);
        push(1, 1'b1, 'h0014, 32'hDEADBEEF, 7'h55);
        @(posedge clk);
        #1 rst_l = 1'b1;
        drain("parallel", DEPTH + 100);

        push(0, 1'b0, 'h0014, '0, '0);
        drain("readback", 50);

        for (int i = 0; i < 4; i++) begin
            push(0, 1'b0, 'h0000, '0, '0);
            push(1, 1'b0, 'h0010, '0, '0);
        end
        drain("conflict", 50);

        for (int i = 0; i < 8; i++)
            push(1, 1'b0, (i % 4) * 4 + (i / 4) * 16, '0, '0);
        drain("stream", 50);

        push(0, 1'b1, 'h0104, 32'h1234, 7'h2A);
        drain("wr", 50);
        push(1, 1'b0, 'h0104, '0, '0);
        drain("rd", 50);

        for (int i = 0; i < 200; i++) begin
            for (int p = 0; p < 2; p++)
                push(p, 1'($urandom_range(0, 1)),
                     ($urandom_range(0, 3) << 4) | ($urandom_range(0, 3) << 2) | $urandom_range(0, 3),
                     $urandom, 7'($urandom));
        end
        drain("random", 2000);

        push(0, 1'b0, 'h0104, '0, '0);
        g0 = gcount[0];
        n = 0;
        while (gcount[0] == g0 && n < 50) begin
            @(posedge clk);
            n++;
        end
        chk("reset_grant_seen", {63'd0, gcount[0] != g0}, 64'd1);
        @(posedge clk);
        #3 rst_l = 1'b0;
        #1;
        chk("reset_init_done_now", {63'd0, init_done}, 64'd0);
        chk("reset_rvalid_now", {62'd0, rvalid}, 64'd0);
        repeat (3) @(posedge clk);
        #1 rst_l = 1'b1;
        push(1, 1'b0, 'h0104, '0, '0);
        drain("after_reset", DEPTH + 100);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
